cascade_updown_counter: RTL and testbench

// - N-digit cascaded up/down counter, each digit with its own runtime wrap limit (BCD or mixed radix, e.g. MM:SS).
// - Generalises the single-digit borrow counter:
//   - direction select
//   - synchronous load
//   - wrap or saturate at the terminal count
//   - sticky expiry flag
// - Feeds the 7-segment display scanner; enable comes from the 1 Hz / 100 Hz tick divider in timer/stopwatch tops.

---
 rtl/cascade_updown_counter_pkg.sv | 13 +
 rtl/cascade_updown_counter_digit.sv | 38 +++
 rtl/cascade_updown_counter.sv | 76 +++++++
 tb/tb_cascade_updown_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cascade_updown_counter_pkg.sv
// Shared constants for the cascaded up/down counter and its per-digit cell.
// The slice macro assumes a DIGIT_W parameter in the scope where it is used.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV
`define CNT_DIGIT(i) [(i)*DIGIT_W +: DIGIT_W]

package counter_pkg;
  localparam int         DIGIT_W_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX         = 4'd9;
  localparam logic [3:0] SEXA_MAX        = 4'd5;
endpackage

`endif

// File: rtl/cascade_updown_counter_digit.sv
// One counter digit: register plus wrap-aware step logic against a runtime limit.
module counter_digit
  import counter_pkg::*;
#(
  parameter int DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] init,
  input  logic               step_in,
  input  logic               up_dn,
  input  logic               hold,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] q,
  output logic               at_bnd
);
  logic [DIGIT_W-1:0] r_q;
  logic [DIGIT_W-1:0] w_next;

  // >= so a digit loaded above its limit still wraps on the next up step
  assign at_bnd = up_dn ? (r_q >= limit) : (r_q == '0);

  always_comb begin
    w_next = r_q;
    if (up_dn) w_next = at_bnd ? '0 : r_q + 1'b1;
    else       w_next = at_bnd ? limit : r_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_q <= init;
    else if (load)            r_q <= load_d;
    else if (step_in && !hold) r_q <= w_next;
  end

  assign q = r_q;
endmodule

// File: rtl/cascade_updown_counter.sv
// N-digit cascaded up/down counter with per-digit limits, wrap/saturate and a
// sticky expiry flag; the step ripples through all digits in one cycle.
module cascade_updown_counter
  import counter_pkg::*;
#(
  parameter int                              NUM_DIGITS = 4,
  parameter int                              DIGIT_W    = DIGIT_W_DEFAULT,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   INIT_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          wrap_en,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] limit,
  output logic [NUM_DIGITS*DIGIT_W-1:0] val,
  output logic                          carry_out,
  output logic                          borrow_out,
  output logic                          at_zero,
  output logic                          expired
);
  logic [NUM_DIGITS:0]   w_step;
  logic [NUM_DIGITS-1:0] w_bnd;
  logic [NUM_DIGITS-1:0] w_dn_z;
  logic                  w_term;
  logic                  w_hold;
  logic                  w_set_exp;
  logic                  r_expired;

  assign w_step[0] = en;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      counter_digit #(.DIGIT_W(DIGIT_W)) u_dig (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (INIT_VAL `CNT_DIGIT(i)),
        .step_in (w_step[i]),
        .up_dn   (up_dn),
        .hold    (w_hold),
        .load    (load),
        .load_d  (load_val `CNT_DIGIT(i)),
        .limit   (limit `CNT_DIGIT(i)),
        .q       (val `CNT_DIGIT(i)),
        .at_bnd  (w_bnd[i])
      );

      assign w_step[i+1] = w_step[i] & w_bnd[i];

      // Down-mode only: will this digit read zero after the pending step?
      assign w_dn_z[i] = w_step[i]
                       ? (w_bnd[i] ? (limit `CNT_DIGIT(i) == '0)
                                   : (val `CNT_DIGIT(i) == DIGIT_W'(1)))
                       : w_bnd[i];
    end
  endgenerate

  // Step rippled out of the top digit == every digit at boundary with en
  assign w_term     = w_step[NUM_DIGITS];
  assign w_hold     = w_term & ~wrap_en;
  assign carry_out  = w_term &  up_dn & ~load;
  assign borrow_out = w_term & ~up_dn & ~load;
  assign at_zero    = (val == '0);

  assign w_set_exp = en & ~up_dn & ~load & (w_hold | (&w_dn_z));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_expired <= 1'b0;
    else if (load)      r_expired <= 1'b0;
    else if (w_set_exp) r_expired <= 1'b1;
  end

  assign expired = r_expired;
endmodule

// File: tb/tb_cascade_updown_counter.sv
// Scoreboard bench: driver queues expected flags/value per cycle, monitor checks at negedge.
module tb_cascade_updown_counter;
  import counter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         en = 1'b0, up_dn = 1'b0, wrap_en = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0, limit = '0;
  logic [W-1:0] val;
  logic         carry_out, borrow_out, at_zero, expired;

  int n_tests = 0, n_fail = 0, cycle = 0;

  typedef struct {
    int           cyc;
    bit           is_val;
    logic [W-1:0] v;
    logic         a;
    logic         b;
    string        name;
  } exp_t;

  exp_t q[$];

  logic [W-1:0] L_MMSS, L_BCD;

  cascade_updown_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .wrap_en(wrap_en),
    .load(load), .load_val(load_val), .limit(limit), .val(val),
    .carry_out(carry_out), .borrow_out(borrow_out), .at_zero(at_zero),
    .expired(expired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      e = q.pop_front();
      if (e.is_val) begin
        chk({e.name, " val"}, val, e.v);
        chk({e.name, " expired"}, W'(expired), W'(e.a));
        chk({e.name, " at_zero"}, W'(at_zero), W'(e.v == '0));
      end else begin
        chk({e.name, " carry_out"}, W'(carry_out), W'(e.a));
        chk({e.name, " borrow_out"}, W'(borrow_out), W'(e.b));
      end
    end
  end

  // Apply one cycle of inputs; ec/eb are the flags during it, ev/ee the state after the edge
  task automatic cyc(input logic i_en, input logic i_up, input logic i_wrap, input logic i_ld,
                     input logic [W-1:0] i_lv, input logic [W-1:0] i_lim,
                     input logic ec, input logic eb, input logic [W-1:0] ev, input logic ee,
                     input string nm);
    @(posedge clk); #1;
    en = i_en; up_dn = i_up; wrap_en = i_wrap; load = i_ld;
    load_val = i_lv; limit = i_lim;
    q.push_back('{cycle,     1'b0, '0, ec, eb,   nm});
    q.push_back('{cycle + 1, 1'b1, ev, ee, 1'b0, nm});
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    chk("scoreboard drain", W'(q.size()), '0);
  endtask

  function automatic logic [W-1:0] mmss(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  initial begin
    L_MMSS = {BCD_MAX, BCD_MAX, SEXA_MAX, BCD_MAX};
    L_BCD  = {BCD_MAX, BCD_MAX, BCD_MAX, BCD_MAX};

    #2;
    chk("reset val", val, '0);
    chk("reset expired", W'(expired), '0);
    chk("reset carry_out", W'(carry_out), '0);
    chk("reset borrow_out", W'(borrow_out), '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // MM:SS countdown 01:30 -> 00:59, limits per digit {9,5,9,9} from digit 0 up
    cyc(0, 0, 1, 1, 16'h0130, L_MMSS, 0, 0, 16'h0130, 0, "t1 load");
    for (int s = 89; s >= 59; s--)
      cyc(1, 0, 1, 0, '0, L_MMSS, 0, 0, mmss(s), 0, "t1 down");

    // Saturating countdown to zero and expiry
    cyc(0, 0, 0, 1, 16'h0001, L_MMSS, 0, 0, 16'h0001, 0, "t2 load");
    cyc(1, 0, 0, 0, '0, L_MMSS, 0, 0, 16'h0000, 1, "t2 pulse1");
    cyc(1, 0, 0, 0, '0, L_MMSS, 0, 1, 16'h0000, 1, "t2 pulse2");
    cyc(0, 0, 0, 0, '0, L_MMSS, 0, 0, 16'h0000, 1, "t2 idle");

    // Up terminal count: wrap then saturate
    cyc(0, 1, 1, 1, 16'h9999, L_BCD, 0, 0, 16'h9999, 0, "t3 load");
    cyc(1, 1, 1, 0, '0, L_BCD, 1, 0, 16'h0000, 0, "t3 wrap");
    cyc(0, 1, 0, 1, 16'h9999, L_BCD, 0, 0, 16'h9999, 0, "t3 reload");
    cyc(1, 1, 0, 0, '0, L_BCD, 1, 0, 16'h9999, 0, "t3 sat");

    // Load beats en; load clears expired and masks borrow_out
    cyc(0, 0, 0, 1, 16'h0000, L_BCD, 0, 0, 16'h0000, 0, "t4 load0");
    cyc(1, 0, 0, 0, '0, L_BCD, 0, 1, 16'h0000, 1, "t4 expire");
    cyc(1, 0, 0, 1, 16'h0042, L_BCD, 0, 0, 16'h0042, 0, "t4 load+en");

    // Down wrap from all-zero lands on all-limit without expiring
    cyc(0, 0, 1, 1, 16'h0000, L_MMSS, 0, 0, 16'h0000, 0, "t4b load0");
    cyc(1, 0, 1, 0, '0, L_MMSS, 0, 1, 16'h9959, 0, "t4b wrap dn");

    // Digit loaded above its limit
    cyc(0, 1, 1, 1, 16'h000C, L_BCD, 0, 0, 16'h000C, 0, "t5 load C");
    cyc(1, 1, 1, 0, '0, L_BCD, 0, 0, 16'h0010, 0, "t5 up over");
    cyc(0, 0, 1, 1, 16'h000C, L_BCD, 0, 0, 16'h000C, 0, "t5 reload C");
    cyc(1, 0, 1, 0, '0, L_BCD, 0, 0, 16'h000B, 0, "t5 dn over");

    // Expired survives up counting, then async reset mid-count
    cyc(0, 0, 0, 1, 16'h0001, L_BCD, 0, 0, 16'h0001, 0, "t6 load");
    cyc(1, 0, 0, 0, '0, L_BCD, 0, 0, 16'h0000, 1, "t6 expire");
    cyc(1, 1, 1, 0, '0, L_BCD, 0, 0, 16'h0001, 1, "t6 up1");
    cyc(1, 1, 1, 0, '0, L_BCD, 0, 0, 16'h0002, 1, "t6 up2");
    drain();
    rst_n = 1'b0;
    #1;
    chk("t6 async reset val", val, '0);
    chk("t6 async reset expired", W'(expired), '0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6 reset held val", val, '0);
    rst_n = 1'b1;
    cyc(1, 1, 1, 0, '0, L_BCD, 0, 0, 16'h0001, 0, "t6 resume");
    cyc(0, 1, 1, 0, '0, L_BCD, 0, 0, 16'h0001, 0, "t6 idle");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
